// File: rtl/alu_issue_unit_pkg.sv
// Shared types for the ALU issue path: opcode encoding and the queued command record.
package alu_issue_unit_pkg;

    typedef enum logic [2:0] {
        OP_NOT = 3'b000,
        OP_AND = 3'b001,
        OP_OR  = 3'b010,
        OP_XOR = 3'b011,
        OP_SHL = 3'b100,
        OP_SHR = 3'b101,
        OP_CUT = 3'b110,
        OP_ADD = 3'b111
    } alu_op_e;

    // 69-bit queued command: 3 + 32 + 32 + 1 + 1
    typedef struct packed {
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        chain;
    } cmd_entry_t;

endpackage

// File: rtl/alu_issue_unit_if.sv
// Command, response and downstream-ALU signals of the issue unit.
interface alu_issue_unit_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        cmd_cin;
    logic        cmd_chain;

    logic [2:0]  alu_opcode;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_cin;
    logic [31:0] alu_result;
    logic        alu_cout;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_cout;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, cmd_chain,
        output cmd_ready,
        output alu_opcode, alu_a, alu_b, alu_cin,
        input  alu_result, alu_cout,
        output rsp_valid, rsp_result, rsp_cout,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, cmd_chain,
        input  cmd_ready,
        input  alu_opcode, alu_a, alu_b, alu_cin,
        output alu_result, alu_cout,
        input  rsp_valid, rsp_result, rsp_cout,
        output rsp_ready
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// DEPTH-entry synchronous command FIFO with occupancy count; head is read combinationally.
module alu_cmd_fifo
    import alu_issue_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  cmd_entry_t               wdata,
    input  logic                     pop,
    output cmd_entry_t               rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    cmd_entry_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        rdata   = mem[rd_ptr];
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Queues ALU commands, presents the head to an external ALU and registers its result.
module alu_issue_unit
    import alu_issue_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    alu_issue_unit_if.slave          bus,
    output logic                     carry_flag,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    cmd_entry_t push_entry;
    cmd_entry_t head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       head_ok;
    logic       issue;

    assign push_entry = '{op:    alu_op_e'(bus.cmd_op),
                          a:     bus.cmd_a,
                          b:     bus.cmd_b,
                          cin:   bus.cmd_cin,
                          chain: bus.cmd_chain};

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.cmd_valid && bus.cmd_ready),
        .wdata (push_entry),
        .pop   (issue),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Reset forces the idle view immediately, before the clearing edge lands.
    always_comb begin
        bus.cmd_ready  = rst || !fifo_full;
        head_ok        = !fifo_empty && !rst;
        issue          = head_ok && (!bus.rsp_valid || bus.rsp_ready);
        bus.alu_opcode = '0;
        bus.alu_a      = '0;
        bus.alu_b      = '0;
        bus.alu_cin    = 1'b0;
        if (head_ok) begin
            bus.alu_opcode = head.op;
            bus.alu_a      = head.a;
            bus.alu_b      = head.b;
            bus.alu_cin    = head.chain ? carry_flag : head.cin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_cout   <= 1'b0;
            carry_flag     <= 1'b0;
        end else if (issue) begin
            bus.rsp_valid  <= 1'b1;
            bus.rsp_result <= bus.alu_result;
            bus.rsp_cout   <= bus.alu_cout;
            if (head.op == OP_ADD) carry_flag <= bus.alu_cout;
        end else if (bus.rsp_ready) begin
            bus.rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 Parameter: DEPTH, default 4, command FIFO entries (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  upstream command present.
REQ-005 cmd_ready  output  1  unit can accept a command this cycle.
REQ-006 cmd_op  input  3  ALU opcode: 000 NOT, 001 AND, 010 OR, 011 XOR, 100 SHL, 101 SHR, 110 CUT, 111 ADD.
REQ-007 cmd_a, cmd_b  input  32 each  operands.
REQ-008 cmd_cin  input  1  explicit carry-in, used when cmd_chain=0.
REQ-009 cmd_chain  input  1  1 = carry-in taken from internal carry flag.
REQ-010 alu_opcode / alu_a / alu_b / alu_cin  output  3/32/32/1  drive the downstream 32-bit unsigned ALU.
REQ-011 alu_result / alu_cout  input  32/1  combinational ALU response.
REQ-012 rsp_valid  output  1  result register holds an unconsumed result.
REQ-013 rsp_ready  input  1  consumer accepts result.
REQ-014 rsp_result / rsp_cout  output  32/1  captured result and carry.
REQ-015 carry_flag  output  1  carry from most recent issued ADD.
REQ-016 fifo_count  output  $clog2(DEPTH)+1  occupied FIFO entries.

Function
REQ-017 Command accepted when cmd_valid && cmd_ready at a rising edge; fields {op,a,b,cin,chain} written to FIFO tail.
REQ-018 cmd_ready SHALL equal (fifo_count != DEPTH); no bypass, no push into a full FIFO even if a pop occurs the same cycle.
REQ-019 Issue condition: FIFO non-empty AND (rsp_valid==0 OR rsp_ready==1).
REQ-020 While FIFO non-empty, alu_* outputs SHALL combinationally present the head entry; alu_cin = chain ? carry_flag : cin; when empty all alu_* outputs SHALL be 0.
REQ-021 On issue edge: pop head, load rsp_result<=alu_result, rsp_cout<=alu_cout, rsp_valid<=1.
REQ-022 On issue of op 111, carry_flag<=alu_cout; other opcodes leave carry_flag unchanged.
REQ-023 rsp_valid falls on rsp_ready edge only when no issue occurs that edge; simultaneous consume+issue keeps rsp_valid=1 with new data.
REQ-024 rsp_result/rsp_cout SHALL be stable while rsp_valid && !rsp_ready.
REQ-025 Minimum latency: command accepted at edge N -> rsp_valid=1 after edge N+1; sustained throughput one result/cycle with rsp_ready=1.
REQ-026 Simultaneous push and pop: fifo_count unchanged; pointers wrap modulo DEPTH.
REQ-027 Back-to-back chained ADDs SHALL use carry_flag updated by the immediately preceding issued ADD (no stale carry).
REQ-028 Results returned strictly in command order.

Reset
REQ-029 rst=1 at an edge SHALL clear FIFO pointers and fifo_count to 0, rsp_valid, rsp_result, rsp_cout, carry_flag to 0, discarding queued and pending work, regardless of handshakes that cycle.
REQ-030 During and after reset cycle: cmd_ready=1, alu_* outputs=0.

Structure
REQ-031 Shared package SHALL hold opcode constants (OP_NOT..OP_ADD) and the command-entry record type (op, a, b, cin, chain; 69 bits), reused by the ALU.
REQ-032 One sub-module: alu_cmd_fifo (parameterised DEPTH-entry synchronous FIFO with count); issue/response control stays in alu_issue_unit.
REQ-033 The ALU itself SHALL NOT be instantiated inside this block; connection is via alu_* ports at top level.

Verification
REQ-034 Push NOT a=0x00000000, rsp_ready=1 -> rsp_result=0xFFFFFFFF, rsp_cout=0, two edges after acceptance.
REQ-035 64-bit add: ADD a=0xFFFFFFFF b=0x00000001 cin=0, then ADD a=0 b=0 chain=1 back-to-back -> results 0x00000000/cout 1, then 0x00000001/cout 0; carry_flag ends 0.
REQ-036 Backpressure: rsp_ready=0, DEPTH=4, offer 6 commands -> exactly 5 accepted (4 FIFO + 1 rsp), cmd_ready=0, fifo_count=4; release rsp_ready -> 5 results in order, one per cycle.
REQ-037 SHR a=0x80000000 b=31 followed by XOR chain=1 between two ADDs -> SHR result 0x00000001; XOR does not alter carry_flag.
REQ-038 Reset with 3 queued and rsp_valid=1 -> next cycle fifo_count=0, rsp_valid=0, carry_flag=0, cmd_ready=1; no stale result emerges afterwards.
